pulpino_qsys_test_core: RTL and testbench

- FPGA board-level bring-up block for the PULPino/Qsys test system.
- Clocked from the 50 MHz board clock; drives the 10 red LEDs from the 10 slide switches and push-keys.
- Shows core status: a boot sequence, then a run indicator and heartbeat.
- Provides four switch-selected LED display modes so board wiring and the clock/reset tree can be checked before the full SoC is integrated.

---
 rtl/pulpino_qsys_test_core.sv | 204 ++++++++++++++++++++
 tb/tb_pulpino_qsys_test_core.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulpino_qsys_test_core.sv
// pulpino_qsys_test_core
// Board bring-up block for the PULPino/Qsys test system. After reset it runs a
// lamp-test boot sequence, then shows a run indicator, a heartbeat and one of
// four switch-selected LED display modes (mirror, counter, scan, invert).
//
// Ports:
//   CLOCK_50  in   1   system clock, rising edge
//   reset     in   1   asynchronous active-high reset
//   KEY       in   4   active-low keys: [1]=freeze, [2]=step, [3]=clear, [0] unused
//   SW        in   10  [9:8]=display mode, [7:0]=data
//   LEDR      out  10  [9]=heartbeat, [8]=run, [7:0]=display (all registered)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RESET | held in reset, all LEDs off
// ST_BOOT  | lamp test for BOOT_CYCLES clocks (LEDR[7:0]=FF)
// ST_RUN   | run LED on, heartbeat and display modes active (terminal)
module pulpino_qsys_test_core #(
    parameter int BOOT_CYCLES   = 16,
    parameter int HEARTBEAT_DIV = 25000000,
    parameter int STEP_DIV      = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR
);

    // Zero-valued parameters degrade to 1 so the terminal counts stay valid.
    localparam int BOOT_EFF = (BOOT_CYCLES < 1) ? 1 : BOOT_CYCLES;
    localparam int HB_EFF   = (HEARTBEAT_DIV < 1) ? 1 : HEARTBEAT_DIV;
    localparam int STEP_EFF = (STEP_DIV < 1) ? 1 : STEP_DIV;
    localparam int BOOT_W   = $clog2(BOOT_EFF) + 1;
    localparam int HB_W     = $clog2(HB_EFF + 1);
    localparam int STEP_W   = $clog2(STEP_EFF + 1);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_EFF - 1);
    localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HB_EFF - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_EFF - 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_BOOT  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [9:0]        sw_s1, sw_s2;
    logic [2:0]        key_s1, key_s2, key_d;
    logic [2:0]        key_press;
    logic [BOOT_W-1:0] boot_cnt;
    logic [HB_W-1:0]   hb_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic              hb;
    logic              run_led;
    logic [7:0]        led_disp;
    logic [7:0]        cnt;
    logic [7:0]        scan;
    logic              scan_dir;     // 0 = shifting left, 1 = shifting right
    logic              scan_dir_eff;
    logic [7:0]        disp;
    logic              run;
    logic              freeze;
    logic              clear;
    logic              div_tick;
    logic              tick;
    logic [1:0]        mode;
    logic              unused_key0;

    // KEY[0] only feeds the external reset path.
    assign unused_key0 = KEY[0];

    // Input synchronisers; key_d is one stage later for falling-edge detect.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            key_s1 <= 3'b111;
            key_s2 <= 3'b111;
            key_d  <= 3'b111;
        end else begin
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
            key_s1 <= KEY[3:1];
            key_s2 <= key_s1;
            key_d  <= key_s2;
        end
    end

    assign key_press = key_d & ~key_s2;
    assign run       = (state_q == ST_RUN);
    assign mode      = sw_s2[9:8];
    assign freeze    = ~key_s2[0];
    assign clear     = run & key_press[2];
    assign div_tick  = run & (step_cnt == STEP_LAST);
    assign tick      = div_tick | (run & key_press[1]);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state_q <= ST_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = ST_BOOT;
            ST_BOOT:  if (boot_cnt == BOOT_LAST) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)                  boot_cnt <= '0;
        else if (state_q == ST_BOOT) boot_cnt <= boot_cnt + 1'b1;
        else                        boot_cnt <= '0;
    end

    // Heartbeat and step divider only run in RUN, so both start from zero on entry.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else if (!run) begin
            hb_cnt <= '0;
            hb     <= 1'b0;
        end else if (hb_cnt == HB_LAST) begin
            hb_cnt <= '0;
            hb     <= ~hb;
        end else begin
            hb_cnt <= hb_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset)                   step_cnt <= '0;
        else if (!run || clear || div_tick) step_cnt <= '0;
        else                         step_cnt <= step_cnt + 1'b1;
    end

    // Bounce at the ends regardless of the stored direction.
    always_comb begin
        scan_dir_eff = scan_dir;
        if (scan == 8'h80)      scan_dir_eff = 1'b1;
        else if (scan == 8'h01) scan_dir_eff = 1'b0;
    end

    // Clear has priority over a coincident tick.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cnt      <= 8'h00;
            scan     <= 8'h01;
            scan_dir <= 1'b0;
        end else if (clear) begin
            cnt      <= 8'h00;
            scan     <= 8'h01;
            scan_dir <= 1'b0;
        end else if (tick) begin
            if (mode == 2'b01) cnt <= cnt + 8'h01;
            if (mode == 2'b10) begin
                scan     <= scan_dir_eff ? (scan >> 1) : (scan << 1);
                scan_dir <= scan_dir_eff;
            end
        end
    end

    always_comb begin
        disp = sw_s2[7:0];
        case (mode)
            2'b00: disp = sw_s2[7:0];
            2'b01: disp = cnt;
            2'b10: disp = scan;
            2'b11: disp = ~sw_s2[7:0];
            default: disp = sw_s2[7:0];
        endcase
    end

    // Outputs are registered from the next state so BOOT shows FF on its first cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            led_disp <= 8'h00;
            run_led  <= 1'b0;
        end else begin
            case (state_d)
                ST_BOOT: begin
                    led_disp <= 8'hFF;
                    run_led  <= 1'b0;
                end
                ST_RUN: begin
                    run_led <= 1'b1;
                    if (!(run && freeze)) led_disp <= disp;
                end
                default: begin
                    led_disp <= 8'h00;
                    run_led  <= 1'b0;
                end
            endcase
        end
    end

    assign LEDR = {hb, run_led, led_disp};

endmodule

// File: tb/tb_pulpino_qsys_test_core.sv
module tb_pulpino_qsys_test_core;

    logic       clk;
    logic       reset;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic [9:0] LEDR;
    logic [9:0] LEDR1;

    int n_checks = 0;
    int n_fail   = 0;

    // Main instance: fast heartbeat, step every 2 cycles.
    pulpino_qsys_test_core #(
        .BOOT_CYCLES(16), .HEARTBEAT_DIV(4), .STEP_DIV(2)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .KEY(KEY), .SW(SW), .LEDR(LEDR)
    );

    // Second instance with a tick every cycle, used for the scan sequence.
    pulpino_qsys_test_core #(
        .BOOT_CYCLES(16), .HEARTBEAT_DIV(4), .STEP_DIV(1)
    ) dut1 (
        .CLOCK_50(clk), .reset(reset), .KEY(KEY), .SW(SW), .LEDR(LEDR1)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] scan_exp(input int j);
        int idx;
        logic [7:0] one;
        one = 8'h01;
        idx = j % 14;
        if (idx <= 7) return one << idx;
        return one << (14 - idx);
    endfunction

    // Press KEY[3]; returns just after the edge that applies the clear.
    task automatic press_clear();
        KEY[3] = 1'b0;
        step(3);
        KEY[3] = 1'b1;
    endtask

    task automatic check_boot(input string name);
        for (int i = 0; i < 16; i++) begin
            step(1);
            n_checks++;
            if (LEDR !== 10'h0FF) begin
                n_fail++;
                $display("FAIL %s lamp cycle %0d: got %h expected %h", name, i, LEDR, 10'h0FF);
            end
        end
        step(1);
        n_checks++;
        if (LEDR !== 10'h100) begin
            n_fail++;
            $display("FAIL %s run entry: got %h expected %h", name, LEDR, 10'h100);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        SW    = 10'h000;
        KEY   = 4'hF;
        #15;
        n_checks++;
        if (LEDR !== 10'h000 || LEDR1 !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_leds: got %h/%h expected 000", LEDR, LEDR1);
        end
        #5 reset = 1'b0;
        check_boot("boot");
    endtask

    task automatic test_mirror_invert();
        SW = 10'h0A5;
        step(2);
        n_checks++;
        if (LEDR[7:0] !== 8'h00) begin
            n_fail++;
            $display("FAIL mirror_early: got %h expected %h", LEDR[7:0], 8'h00);
        end
        step(1);
        n_checks++;
        if (LEDR[7:0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL mirror_a5: got %h expected %h", LEDR[7:0], 8'hA5);
        end
        SW = 10'h3FF;
        step(2);
        n_checks++;
        if (LEDR[7:0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL invert_early: got %h expected %h", LEDR[7:0], 8'hA5);
        end
        step(1);
        n_checks++;
        if (LEDR[7:0] !== 8'h00 || LEDR[8] !== 1'b1) begin
            n_fail++;
            $display("FAIL invert_ff: got %h run %b expected 00 run 1", LEDR[7:0], LEDR[8]);
        end
        SW = 10'h30F;
        step(3);
        n_checks++;
        if (LEDR[7:0] !== 8'hF0) begin
            n_fail++;
            $display("FAIL invert_0f: got %h expected %h", LEDR[7:0], 8'hF0);
        end
    endtask

    task automatic test_counter();
        logic [7:0] exp8;
        logic       prev_hb;
        int         last_t;
        int         ntog;
        SW = 10'h100;
        step(3);
        press_clear();
        prev_hb = LEDR[9];
        last_t  = -1;
        ntog    = 0;
        for (int k = 1; k <= 520; k++) begin
            step(1);
            exp8 = 8'((k - 1) / 2);
            n_checks++;
            if (LEDR[7:0] !== exp8) begin
                n_fail++;
                $display("FAIL counter k=%0d: got %h expected %h", k, LEDR[7:0], exp8);
            end
            if (LEDR[9] !== prev_hb) begin
                ntog++;
                if (last_t >= 0) begin
                    n_checks++;
                    if (k - last_t != 4) begin
                        n_fail++;
                        $display("FAIL heartbeat_period at k=%0d: got %0d expected 4", k, k - last_t);
                    end
                end
                last_t = k;
            end
            prev_hb = LEDR[9];
        end
        n_checks++;
        if (ntog != 130) begin
            n_fail++;
            $display("FAIL heartbeat_toggles: got %0d expected 130", ntog);
        end
    endtask

    task automatic test_scan();
        logic [7:0] exp8;
        SW = 10'h200;
        step(2);
        for (int j = 0; j <= 22; j++) begin
            step(1);
            exp8 = scan_exp(j);
            n_checks++;
            if (LEDR1[7:0] !== exp8) begin
                n_fail++;
                $display("FAIL scan j=%0d: got %h expected %h", j, LEDR1[7:0], exp8);
            end
            if (j == 19) KEY[3] = 1'b0;
            if (j == 22) KEY[3] = 1'b1;
        end
        step(1);
        n_checks++;
        if (LEDR1[7:0] !== 8'h01) begin
            n_fail++;
            $display("FAIL scan_clear: got %h expected %h", LEDR1[7:0], 8'h01);
        end
        step(1);
        n_checks++;
        if (LEDR1[7:0] !== 8'h02) begin
            n_fail++;
            $display("FAIL scan_after_clear: got %h expected %h", LEDR1[7:0], 8'h02);
        end
    endtask

    task automatic test_freeze();
        logic [7:0] exp8;
        logic       prev_hb;
        int         ntog;
        SW = 10'h100;
        step(3);
        press_clear();
        ntog    = 0;
        prev_hb = 1'b0;
        for (int k = 1; k <= 23; k++) begin
            step(1);
            exp8 = (k >= 7 && k <= 22) ? 8'h02 : 8'((k - 1) / 2);
            n_checks++;
            if (LEDR[7:0] !== exp8 || LEDR[8] !== 1'b1) begin
                n_fail++;
                $display("FAIL freeze k=%0d: got %h run %b expected %h run 1", k, LEDR[7:0], LEDR[8], exp8);
            end
            if (k >= 7 && k <= 22 && LEDR[9] !== prev_hb) ntog++;
            prev_hb = LEDR[9];
            if (k == 4)  KEY[1] = 1'b0;
            if (k == 20) KEY[1] = 1'b1;
        end
        n_checks++;
        if (ntog != 4) begin
            n_fail++;
            $display("FAIL freeze_heartbeat: got %0d toggles expected 4", ntog);
        end
    endtask

    task automatic test_step_key();
        logic [7:0] exp8;
        press_clear();
        KEY[2] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            exp8 = 8'((k - 1) / 2 + ((k >= 4) ? 1 : 0));
            n_checks++;
            if (LEDR[7:0] !== exp8) begin
                n_fail++;
                $display("FAIL step_key k=%0d: got %h expected %h", k, LEDR[7:0], exp8);
            end
            if (k == 4)  KEY[2] = 1'b1;
            if (k == 9)  KEY[2] = 1'b0;
            if (k == 14) KEY[2] = 1'b1;
        end
    endtask

    task automatic test_reset_mid_run();
        SW = 10'h000;
        #4 reset = 1'b1;
        #1;
        n_checks++;
        if (LEDR !== 10'h000 || LEDR1 !== 10'h000) begin
            n_fail++;
            $display("FAIL async_reset: got %h/%h expected 000", LEDR, LEDR1);
        end
        #4 reset = 1'b0;
        check_boot("reboot");
    endtask

    initial begin
        test_reset();
        test_mirror_invert();
        test_counter();
        test_scan();
        test_freeze();
        test_step_key();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
